// File: rtl/raw_fetch_pkg.sv
// Shared types and helpers for the raw-data fetch arbiter.
// State encoding plus channel-index width helper.
package raw_fetch_pkg;

   typedef enum logic [1:0] {
      INIT,
      ARB,
      WAIT,
      READY
   } fetch_state_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raw_rr_pick.sv
// Rotate-priority picker: first requesting channel at or above ptr,
// wrapping modulo NUM_CH.
module raw_rr_pick
   import raw_fetch_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = ch_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   cand,
   output logic              any_req
);

   logic [CH_W-1:0] idx;

   // Walk from farthest to nearest so the nearest hit wins.
   always_comb begin
      cand = '0;
      idx  = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = CH_W'((int'(ptr) + k) % NUM_CH);
         if (req[idx]) begin
            cand = idx;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/raw_fetch_arb.sv
// Round-robin fetch/present FSM over NUM_CH raw-data FIFOs with
// burst-limited fairness and configurable FIFO read latency.
module raw_fetch_arb
   import raw_fetch_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   parameter  int DATA_W    = 64,
   parameter  int RD_LAT    = 1,
   parameter  int MAX_BURST = 4,
   localparam int CH_W      = ch_w(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        fifo_empty,
   input  logic [NUM_CH*DATA_W-1:0] fifo_rdata,
   output logic [NUM_CH-1:0]        fifo_pop,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   input  logic                     out_accepted,
   output logic                     busy
);

   localparam int BC_W = ch_w(MAX_BURST);

   fetch_state_t    state;
   logic [CH_W-1:0] rr_ptr;
   logic [CH_W-1:0] sel;
   logic [CH_W-1:0] cand;
   logic [CH_W-1:0] nxt_ptr;
   logic [BC_W-1:0] burst_cnt;
   logic            any_req;
   logic            grant;
   logic            burst_ok;
   logic            more;
   logic [DATA_W-1:0] cand_data;
   logic [DATA_W-1:0] sel_data;

   raw_rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_pick (
      .req     (~fifo_empty),
      .ptr     (rr_ptr),
      .cand    (cand),
      .any_req (any_req)
   );

   assign cand_data = fifo_rdata[cand*DATA_W +: DATA_W];
   assign sel_data  = fifo_rdata[sel*DATA_W +: DATA_W];

   assign grant    = (state == ARB) && enable && any_req;
   assign burst_ok = (int'(burst_cnt) + 1) < MAX_BURST;
   assign more     = (state == READY) && out_accepted
                   && burst_ok && !fifo_empty[sel];

   assign nxt_ptr = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;

   assign busy = (state == WAIT) || (state == READY);

   // Pops are combinational so the FIFO advances on the grant edge.
   always_comb begin
      fifo_pop = '0;
      unique case (1'b1)
         grant:   fifo_pop[cand] = 1'b1;
         more:    fifo_pop[sel]  = 1'b1;
         default: fifo_pop = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= INIT;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         sel       <= '0;
      end else begin
         unique case (state)
            INIT: state <= ARB;
            ARB: begin
               if (grant) begin
                  sel       <= cand;
                  burst_cnt <= '0;
                  if (RD_LAT == 0) begin
                     out_data  <= cand_data;
                     out_ch    <= cand;
                     out_valid <= 1'b1;
                     state     <= READY;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               out_data  <= sel_data;
               out_ch    <= sel;
               out_valid <= 1'b1;
               state     <= READY;
            end
            READY: begin
               if (out_accepted) begin
                  if (more) begin
                     burst_cnt <= burst_cnt + 1'b1;
                     if (RD_LAT == 0) begin
                        out_data <= sel_data;
                     end else begin
                        out_valid <= 1'b0;
                        state     <= WAIT;
                     end
                  end else begin
                     out_valid <= 1'b0;
                     rr_ptr    <= nxt_ptr;
                     burst_cnt <= '0;
                     state     <= ARB;
                  end
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule
